// File: rtl/fdiv_seq.sv
// fdiv_seq: control sequencer for the fdiv floating-point divider.
// It captures the operands on start and holds them on N/D. It then walks fdiv
// through LOAD, INIT, ITERS pairs of MULA/MULB and ROUND, and finally latches
// the quotient and pulses done.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; N/D/q_out hold their last values
// LOAD  | fdiv loads operands from N/D
// INIT  | fdiv seeds the reciprocal estimate
// MULA  | first half of a refinement iteration
// MULB  | second half of a refinement iteration; iter_cnt decides loop/exit
// ROUND | fdiv rounds; q_in is captured on the exit edge
// DONE  | q_out valid, done pulses for this single cycle
module fdiv_seq #(
    parameter int ITERS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] n_in,
    input  logic [31:0] d_in,
    input  logic [31:0] q_in,
    output logic [31:0] N,
    output logic [31:0] D,
    output logic [1:0]  c1,
    output logic [5:0]  op,
    output logic        rm,
    output logic        busy,
    output logic        done,
    output logic [31:0] q_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_MULA  = 3'd3,
        ST_MULB  = 3'd4,
        ST_ROUND = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);

    state_t      state_q, state_d;
    logic [3:0]  iter_cnt_q, iter_cnt_d;
    logic [31:0] n_q, n_d;
    logic [31:0] dv_q, dv_d;
    logic [31:0] q_out_q, q_out_d;
    logic [1:0]  c1_q, c1_d;
    logic [5:0]  op_q, op_d;
    logic        rm_q, rm_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state, operand capture and quotient capture.
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        n_d        = n_q;
        dv_d       = dv_q;
        q_out_d    = q_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    n_d        = n_in;
                    dv_d       = d_in;
                    iter_cnt_d = 4'd0;
                end
            end
            ST_LOAD: state_d = ST_INIT;
            ST_INIT: state_d = ST_MULA;
            ST_MULA: state_d = ST_MULB;
            ST_MULB: begin
                if (iter_cnt_q == ITER_LAST) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d    = ST_MULA;
                    iter_cnt_d = iter_cnt_q + 4'd1;
                end
            end
            ST_ROUND: begin
                state_d = ST_DONE;
                q_out_d = q_in;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs line up
    // with the state register and carry no path from the inputs.
    always_comb begin
        c1_d   = 2'b00;
        op_d   = 6'b000000;
        rm_d   = 1'b0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD:  begin c1_d = 2'b00; op_d = 6'b010000; end
            ST_INIT:  begin c1_d = 2'b01; op_d = 6'b001100; end
            ST_MULA:  begin c1_d = 2'b10; op_d = 6'b010001; end
            ST_MULB:  begin c1_d = 2'b11; op_d = 6'b001101; end
            ST_ROUND: begin c1_d = 2'b11; op_d = 6'b100010; rm_d = 1'b1; end
            default:  begin c1_d = 2'b00; op_d = 6'b000000; end
        endcase
    end

    // State and registered outputs; reset aborts any operation at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            iter_cnt_q <= 4'd0;
            n_q        <= 32'd0;
            dv_q       <= 32'd0;
            q_out_q    <= 32'd0;
            c1_q       <= 2'b00;
            op_q       <= 6'b000000;
            rm_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            n_q        <= n_d;
            dv_q       <= dv_d;
            q_out_q    <= q_out_d;
            c1_q       <= c1_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign N     = n_q;
    assign D     = dv_q;
    assign q_out = q_out_q;
    assign c1    = c1_q;
    assign op    = op_q;
    assign rm    = rm_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: a timeline model (edges since the accepted start) checked
// every cycle against an ITERS=5 instance, plus literal expectations, and a
// directed run of an ITERS=1 instance.
module tb_fdiv_seq;

    localparam int IT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start1 = 1'b0;
    logic [31:0] n_in = 32'd0, d_in = 32'd0, q_in = 32'd0;
    logic [31:0] q_res = 32'h3F99999A;
    logic [31:0] N, D, q_out, N1, D1, q_out1;
    logic [1:0]  c1, c1_1;
    logic [5:0]  op, op_1;
    logic        rm, rm_1, busy, busy_1, done, done_1;

    int checks = 0;
    int failures = 0;
    int unsigned cyc = 0;

    fdiv_seq #(.ITERS(IT)) dut (
        .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in),
        .q_in(q_in), .N(N), .D(D), .c1(c1), .op(op), .rm(rm), .busy(busy),
        .done(done), .q_out(q_out)
    );

    fdiv_seq #(.ITERS(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .n_in(n_in), .d_in(d_in),
        .q_in(q_in), .N(N1), .D(D1), .c1(c1_1), .op(op_1), .rm(rm_1),
        .busy(busy_1), .done(done_1), .q_out(q_out1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: t_m counts edges since the accepted start (1 = LOAD).
    bit          act_m;
    int          t_m;
    logic [31:0] n_m, d_m, q_m;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_m = 1'b0; t_m = 0; n_m = '0; d_m = '0; q_m = '0;
        end else if (act_m) begin
            if (t_m == 3 + 2 * IT) q_m = q_in;
            if (t_m == 4 + 2 * IT) begin act_m = 1'b0; t_m = 0; end
            else t_m++;
        end else if (start) begin
            act_m = 1'b1; t_m = 1; n_m = n_in; d_m = d_in;
        end
    end

    function automatic logic [8:0] exp_ctrl(input int t, input int iters);
        if (t == 1) return {2'b00, 6'b010000, 1'b0};
        if (t == 2) return {2'b01, 6'b001100, 1'b0};
        if (t >= 3 && t <= 2 + 2 * iters)
            return (t % 2 == 1) ? {2'b10, 6'b010001, 1'b0} : {2'b11, 6'b001101, 1'b0};
        if (t == 3 + 2 * iters) return {2'b11, 6'b100010, 1'b1};
        return 9'd0;
    endfunction

    // Mock fdiv: presents the result only during ROUND, noise otherwise.
    always @(negedge clk) begin
        cyc++;
        q_in = (act_m && t_m == 3 + 2 * IT) ? q_res : (32'hBAD00000 | (cyc & 32'hFFFF));
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ctrl", {55'd0, c1, op, rm}, {55'd0, exp_ctrl(t_m, IT)});
        chk("busy_done", {62'd0, busy, done}, {62'd0, act_m, (act_m && t_m == 4 + 2 * IT)});
        chk("n_d", {N, D}, {n_m, d_m});
        chk("q_out", {32'd0, q_out}, {32'd0, q_m});
    end

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        chk(nm, {63'd0, done}, 64'd1);
    endtask

    logic [8:0] seq5 [14];
    logic [8:0] seq1 [6];
    int done_edge;

    initial begin
        seq5[0] = {2'b00, 6'b010000, 1'b0};
        seq5[1] = {2'b01, 6'b001100, 1'b0};
        for (int i = 2; i < 12; i += 2) begin
            seq5[i]   = {2'b10, 6'b010001, 1'b0};
            seq5[i+1] = {2'b11, 6'b001101, 1'b0};
        end
        seq5[12] = {2'b11, 6'b100010, 1'b1};
        seq5[13] = 9'd0;
        seq1[0] = {2'b00, 6'b010000, 1'b0};
        seq1[1] = {2'b01, 6'b001100, 1'b0};
        seq1[2] = {2'b10, 6'b010001, 1'b0};
        seq1[3] = {2'b11, 6'b001101, 1'b0};
        seq1[4] = {2'b11, 6'b100010, 1'b1};
        seq1[5] = 9'd0;

        #2 reset = 1'b0;
        #20 reset = 1'b1;
        @(negedge clk);
        chk("reset_q_out", {32'd0, q_out}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        // Sequence + integration, ITERS=5.
        n_in = 32'h3FC00000; d_in = 32'h3FA00000; q_res = 32'h3F99999A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_in = 32'h12345678; d_in = 32'h9ABCDEF0;
        done_edge = -1;
        for (int e = 0; e < 14; e++) begin
            if (e > 0) @(negedge clk);
            chk($sformatf("seq5_e%0d", e), {55'd0, c1, op, rm}, {55'd0, seq5[e]});
            if (done && done_edge < 0) done_edge = e;
        end
        chk("done_edge", 64'(done_edge), 64'd13);
        chk("q_out_done", {32'd0, q_out}, {32'd0, 32'h3F99999A});
        chk("nd_held", {N, D}, {32'h3FC00000, 32'h3FA00000});
        // Back-to-back: first IDLE cycle re-asserts start.
        @(negedge clk);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        q_res = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_nd", {N, D}, {32'h12345678, 32'h9ABCDEF0});
        repeat (12) @(negedge clk);
        chk("b2b_q_held", {32'd0, q_out}, {32'd0, 32'h3F99999A});
        @(negedge clk);
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_q_new", {32'd0, q_out}, {32'd0, 32'h40000000});
        repeat (3) @(negedge clk);
        chk("q_held_idle", {32'd0, q_out}, {32'd0, 32'h40000000});

        // Start held high while busy, n_in changing each cycle.
        q_res = 32'h3E000000;
        for (int i = 0; i < 20; i++) begin
            n_in = 32'h40000000 + 32'(i);
            start = 1'b1;
            @(negedge clk);
            if (i == 10) chk("hold_n_first", {32'd0, N}, {32'd0, 32'h40000000});
        end
        start = 1'b0;
        chk("hold_n_second", {32'd0, N}, {32'd0, 32'h4000000F});
        wait_done(40, "hold_done");
        repeat (2) @(negedge clk);

        // Reset during the third MULA.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("third_mula", {55'd0, c1, op, rm}, {55'd0, 2'b10, 6'b010001, 1'b0});
        #2 reset = 1'b0;
        #1;
        chk("abort_ctrl", {55'd0, c1, op, rm}, 64'd0);
        chk("abort_flags", {62'd0, busy, done}, 64'd0);
        chk("abort_q_out", {32'd0, q_out}, 64'd0);
        chk("abort_nd", {N, D}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_in = 32'h3F800000; d_in = 32'h40000000; q_res = 32'h3F000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, "fresh_done");
        chk("fresh_q_out", {32'd0, q_out}, {32'd0, 32'h3F000000});
        repeat (2) @(negedge clk);

        // ITERS=1 instance.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int e = 0; e < 6; e++) begin
            if (e > 0) @(negedge clk);
            chk($sformatf("seq1_e%0d", e), {55'd0, c1_1, op_1, rm_1}, {55'd0, seq1[e]});
            chk($sformatf("seq1_done_e%0d", e), {62'd0, busy_1, done_1}, {62'd0, 1'b1, (e == 5)});
        end
        @(negedge clk);
        chk("seq1_idle", {62'd0, busy_1, done_1}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
